// File: rtl/heap_chain_if.sv
// Command and allocator-port bundles for heap_chain.
// master drives requests; slave answers them.
interface hc_cmd_if #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
);
  logic               i_cmd_valid;
  logic               i_cmd_op;
  logic [DATA_SZ-1:0] i_cmd_arg;
  logic               o_cmd_ready;
  logic               o_done;
  logic [DATA_SZ-1:0] o_result;
  logic [ADDR_SZ:0]   o_count;
  logic               o_err;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_arg,
    input  o_cmd_ready, o_done, o_result,
    input  o_count, o_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_arg,
    output o_cmd_ready, o_done, o_result,
    output o_count, o_err
  );
endinterface

interface hc_mem_if #(
  parameter int DATA_SZ = 16
);
  logic               o_al;
  logic [DATA_SZ-1:0] o_adata;
  logic [DATA_SZ-1:0] i_aaddr;
  logic               i_full;
  logic               o_fr;
  logic [DATA_SZ-1:0] o_faddr;
  logic               o_rd;
  logic [DATA_SZ-1:0] o_raddr;
  logic [DATA_SZ-1:0] i_rdata;
  logic               i_err;

  modport master (
    output o_al, o_adata, o_fr, o_faddr,
    output o_rd, o_raddr,
    input  i_aaddr, i_full, i_rdata, i_err
  );

  modport slave (
    input  o_al, o_adata, o_fr, o_faddr,
    input  o_rd, o_raddr,
    output i_aaddr, i_full, i_rdata, i_err
  );
endinterface

// File: rtl/heap_chain.sv
// Builds and reclaims NIL-terminated linked cell chains
// by driving the allocator's alloc/free/read ports.
module heap_chain #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8,
  parameter int MEM_MAX = 1 << ADDR_SZ
) (
  input  logic i_clk,
  input  logic i_rst,
  hc_cmd_if.slave  cmd,
  hc_mem_if.master mem
);
  localparam int CW = ADDR_SZ + 1;
  localparam logic [DATA_SZ-1:0] NIL   = DATA_SZ'(1);
  localparam logic [DATA_SZ-1:0] UNDEF = '0;
  localparam logic [CW-1:0] CMAX = CW'(MEM_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_BUILD, S_BFIN, S_RD,
    S_FR, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;

  logic [DATA_SZ-1:0] p_q;
  logic [DATA_SZ-1:0] res_q;
  logic [CW-1:0]      rem_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_inc;
  logic [CW-1:0]      arg_n;
  logic               head_bad;
  logic               next_bad;
  logic               accept;

  assign arg_n    = cmd.i_cmd_arg[CW-1:0];
  assign cnt_inc  = cnt_q + CW'(1);
  assign accept   = (state == S_IDLE) && cmd.i_cmd_valid;
  // Fixnum-tagged or UNDEF words can never be cell addresses.
  assign head_bad = (cmd.i_cmd_arg == UNDEF) ||
                    cmd.i_cmd_arg[DATA_SZ-1];
  assign next_bad = (mem.i_rdata == UNDEF) ||
                    mem.i_rdata[DATA_SZ-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mem.i_err) begin
      state_nx = S_ERR;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd.i_cmd_valid) begin
            unique case (1'b1)
              !cmd.i_cmd_op && arg_n == '0:
                state_nx = S_DONE;
              !cmd.i_cmd_op && arg_n != '0:
                state_nx = S_BUILD;
              cmd.i_cmd_op && cmd.i_cmd_arg == NIL:
                state_nx = S_DONE;
              cmd.i_cmd_op && cmd.i_cmd_arg != NIL && head_bad:
                state_nx = S_ERR;
              cmd.i_cmd_op && cmd.i_cmd_arg != NIL && !head_bad:
                state_nx = S_RD;
              default: state_nx = S_IDLE;
            endcase
          end
        end
        S_BUILD: begin
          if (mem.i_full)        state_nx = S_ERR;
          else if (rem_q == 1'b1) state_nx = S_BFIN;
        end
        S_BFIN: state_nx = S_DONE;
        S_RD:   state_nx = S_FR;
        S_FR: begin
          if (mem.i_rdata == NIL) state_nx = S_DONE;
          else if (next_bad)      state_nx = S_ERR;
          else if (cnt_inc == CMAX) state_nx = S_ERR;
          else                    state_nx = S_RD;
        end
        S_DONE:  state_nx = S_IDLE;
        S_ERR:   state_nx = S_ERR;
        default: state_nx = S_ERR;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_q   <= '0;
      res_q <= NIL;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            p_q   <= cmd.i_cmd_arg;
            rem_q <= arg_n;
            cnt_q <= '0;
            res_q <= NIL;
          end
        end
        S_BUILD: begin
          if (!mem.i_full) begin
            rem_q <= rem_q - CW'(1);
            cnt_q <= cnt_inc;
          end else begin
            res_q <= (cnt_q != '0) ? mem.i_aaddr : NIL;
          end
        end
        S_BFIN: res_q <= mem.i_aaddr;
        S_FR: begin
          cnt_q <= cnt_inc;
          res_q <= p_q;
          p_q   <= mem.i_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd.o_cmd_ready = 1'b0;
    cmd.o_done      = 1'b0;
    cmd.o_err       = 1'b0;
    mem.o_al        = 1'b0;
    mem.o_adata     = '0;
    mem.o_fr        = 1'b0;
    mem.o_faddr     = '0;
    mem.o_rd        = 1'b0;
    mem.o_raddr     = '0;
    unique case (state)
      S_IDLE: cmd.o_cmd_ready = 1'b1;
      S_BUILD: begin
        // Each new cell points at the previous head.
        mem.o_al    = !mem.i_full;
        mem.o_adata = mem.i_full ? '0 :
                      (cnt_q == '0) ? NIL : mem.i_aaddr;
      end
      S_RD: begin
        mem.o_rd    = 1'b1;
        mem.o_raddr = p_q;
      end
      S_FR: begin
        mem.o_fr    = 1'b1;
        mem.o_faddr = p_q;
      end
      S_DONE:  cmd.o_done = 1'b1;
      S_ERR:   cmd.o_err  = 1'b1;
      default: ;
    endcase
  end

  assign cmd.o_result = res_q;
  assign cmd.o_count  = cnt_q;
endmodule

// File: tb/tb_heap_chain.sv
// Bench for heap_chain: vector table, corner sequences,
// random build/reclaim mix against a linked-heap model.
module tb_heap_chain;
  localparam logic [15:0] NIL = 16'h0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hc_cmd_if cmd ();
  hc_mem_if mem ();

  heap_chain dut (
    .i_clk(clk),
    .i_rst(rst),
    .cmd  (cmd),
    .mem  (mem)
  );

  // Allocator: fresh cells from 0x5000 up, freed cells reused LIFO.
  logic [15:0] heap [256];
  logic [15:0] fstk [1024];
  int          sp = 0;
  int          next_idx = 0;
  logic [15:0] aaddr_r = '0;
  logic [15:0] rdata_r = '0;
  logic        inj_err = 1'b0;
  logic        al_clear = 1'b0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [15:0] poke_val = '0;
  logic [15:0] next_a;
  logic [15:0] al_log[$];
  logic [15:0] rd_log[$];
  logic [15:0] fr_log[$];

  assign next_a = (sp > 0) ? fstk[(sp > 0) ? sp - 1 : 0]
                           : 16'h5000 + 16'(next_idx);
  assign mem.i_full  = (sp == 0) && (next_idx >= 256);
  assign mem.i_aaddr = aaddr_r;
  assign mem.i_rdata = rdata_r;
  assign mem.i_err   = inj_err;

  always @(posedge clk) begin
    if (al_clear) begin
      sp       <= 0;
      next_idx <= 0;
    end else begin
      if (poke_en) heap[poke_idx] <= poke_val;
      if (mem.o_al) begin
        aaddr_r <= next_a;
        heap[next_a[7:0]] <= mem.o_adata;
        al_log.push_back(next_a);
        if (sp > 0) sp <= sp - 1;
        else        next_idx <= next_idx + 1;
      end
      if (mem.o_rd) begin
        rdata_r <= heap[mem.o_raddr[7:0]];
        rd_log.push_back(mem.o_raddr);
      end
      if (mem.o_fr) begin
        if (sp < 1024) fstk[sp] <= mem.o_faddr;
        sp <= sp + 1;
        fr_log.push_back(mem.o_faddr);
      end
    end
  end

  int multi_viol = 0, full_viol = 0, errreq_viol = 0;
  always @(negedge clk) begin
    if (32'(mem.o_al) + 32'(mem.o_fr) + 32'(mem.o_rd) > 1)
      multi_viol <= multi_viol + 1;
    if (mem.o_al && mem.i_full)
      full_viol <= full_viol + 1;
    if (cmd.o_err && (mem.o_al || mem.o_fr || mem.o_rd))
      errreq_viol <= errreq_viol + 1;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic clear_alloc();
    @(negedge clk); al_clear = 1'b1;
    @(negedge clk); al_clear = 1'b0;
  endtask

  task automatic issue(input bit op, input logic [15:0] arg);
    @(negedge clk);
    al_log.delete(); rd_log.delete(); fr_log.delete();
    cmd.i_cmd_valid = 1'b1;
    cmd.i_cmd_op    = op;
    cmd.i_cmd_arg   = arg;
    @(posedge clk); #1;
    cmd.i_cmd_valid = 1'b0;
  endtask

  // cyc = first cycle (edge 0 = acceptance) showing o_done or o_err.
  task automatic run_cmd(input bit op, input logic [15:0] arg,
                         input int budget, output int cyc,
                         output bit saw_err);
    cyc = -1; saw_err = 1'b0;
    issue(op, arg);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (cmd.o_done) begin cyc = c; break; end
      if (cmd.o_err) begin cyc = c; saw_err = 1'b1; break; end
    end
  endtask

  logic [15:0] wq[$];
  task automatic walk(input logic [15:0] h);
    logic [15:0] p;
    p = h;
    wq.delete();
    for (int i = 0; i < 300 && p != NIL; i++) begin
      wq.push_back(p);
      p = heap[p[7:0]];
    end
  endtask

  typedef struct {
    bit          op;
    logic [15:0] arg;
    int          cyc;
    logic [15:0] res;
    int          cnt;
    bit          err;
    int          nreq;
  } vec_t;
  vec_t tv[8];

  logic [15:0] live[$];
  int  cyc;
  bit  se;

  initial begin
    tv[0] = '{1'b0, 16'd3,    5, 16'h5002, 3, 1'b0, 3};
    tv[1] = '{1'b1, 16'h5002, 7, 16'h5000, 3, 1'b0, 6};
    tv[2] = '{1'b0, 16'd0,    1, NIL,      0, 1'b0, 0};
    tv[3] = '{1'b1, NIL,      1, NIL,      0, 1'b0, 0};
    tv[4] = '{1'b0, 16'd2,    4, 16'h5001, 2, 1'b0, 2};
    tv[5] = '{1'b1, 16'h5001, 5, 16'h5000, 2, 1'b0, 4};
    tv[6] = '{1'b1, 16'h8005, 1, NIL,      0, 1'b1, 0};
    tv[7] = '{1'b1, 16'h0000, 1, NIL,      0, 1'b1, 0};

    cmd.i_cmd_valid = 1'b0;
    cmd.i_cmd_op    = 1'b0;
    cmd.i_cmd_arg   = '0;
    al_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", int'(cmd.o_cmd_ready), 1);
    chk("rst_done", int'(cmd.o_done), 0);
    chk("rst_result", int'(cmd.o_result), int'(NIL));
    chk("rst_count", int'(cmd.o_count), 0);
    chk("rst_err", int'(cmd.o_err), 0);
    chk("rst_reqs", int'({mem.o_al, mem.o_fr, mem.o_rd}), 0);
    chk("rst_addrs", int'(mem.o_adata | mem.o_faddr | mem.o_raddr), 0);
    rst = 1'b0; al_clear = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_cmd(tv[i].op, tv[i].arg, 40, cyc, se);
      chk($sformatf("v%0d_cycle", i), cyc, tv[i].cyc);
      chk($sformatf("v%0d_err", i), int'(se), int'(tv[i].err));
      chk($sformatf("v%0d_result", i), int'(cmd.o_result),
          int'(tv[i].res));
      chk($sformatf("v%0d_count", i), int'(cmd.o_count), tv[i].cnt);
      chk($sformatf("v%0d_nreq", i),
          al_log.size() + rd_log.size() + fr_log.size(), tv[i].nreq);
      if (se) reset_dut();
    end

    // Overfill: 257 requested, heap holds 256.
    clear_alloc(); reset_dut();
    run_cmd(1'b0, 16'd257, 300, cyc, se);
    chk("full_cycle", cyc, 258);
    chk("full_err", int'(se), 1);
    chk("full_count", int'(cmd.o_count), 256);
    chk("full_result", int'(cmd.o_result), 16'h50FF);
    chk("full_allocs", al_log.size(), 256);

    // Self-loop cell trips the cycle guard.
    clear_alloc(); reset_dut();
    run_cmd(1'b0, 16'd1, 20, cyc, se);
    chk("loop_build", int'(cmd.o_result), 16'h5000);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 8'h00; poke_val = 16'h5000;
    @(negedge clk); poke_en = 1'b0;
    run_cmd(1'b1, 16'h5000, 600, cyc, se);
    chk("loop_cycle", cyc, 513);
    chk("loop_err", int'(se), 1);
    chk("loop_count", int'(cmd.o_count), 256);
    chk("loop_frees", fr_log.size(), 256);

    // Reset in cycle 3 of a reclaim, then a fresh build.
    clear_alloc(); reset_dut();
    run_cmd(1'b0, 16'd3, 20, cyc, se);
    issue(1'b1, 16'h5002);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_reqs", int'({mem.o_al, mem.o_fr, mem.o_rd}), 0);
    chk("mid_rst_ready", int'(cmd.o_cmd_ready), 1);
    chk("mid_rst_err", int'(cmd.o_err), 0);
    chk("mid_rst_count", int'(cmd.o_count), 0);
    rst = 1'b0;
    run_cmd(1'b0, 16'd1, 20, cyc, se);
    chk("post_rst_cycle", cyc, 3);
    chk("post_rst_result", int'(cmd.o_result), 16'h5002);
    chk("post_rst_count", int'(cmd.o_count), 1);

    // Allocator error mid-build is sticky.
    issue(1'b0, 16'd4);
    @(negedge clk);
    @(negedge clk); inj_err = 1'b1;
    @(negedge clk); inj_err = 1'b0;
    chk("ierr_err", int'(cmd.o_err), 1);
    chk("ierr_ready", int'(cmd.o_cmd_ready), 0);
    chk("ierr_al", int'(mem.o_al), 0);
    repeat (3) @(negedge clk);
    chk("ierr_sticky", int'(cmd.o_err), 1);
    reset_dut();
    chk("ierr_cleared", int'(cmd.o_err), 0);

    // Random mix of builds and reclaims of live chains.
    clear_alloc(); reset_dut();
    for (int t = 0; t < 40; t++) begin
      if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
        int idx, k;
        bit ok;
        logic [15:0] h;
        logic [15:0] exp_q[$];
        idx = $urandom_range(0, live.size() - 1);
        h = live[idx];
        live.delete(idx);
        walk(h);
        exp_q = wq;
        k = exp_q.size();
        run_cmd(1'b1, h, 2 * k + 10, cyc, se);
        chk($sformatf("r%0d_rc_cycle", t), cyc, 2 * k + 1);
        chk($sformatf("r%0d_rc_err", t), int'(se), 0);
        chk($sformatf("r%0d_rc_count", t), int'(cmd.o_count), k);
        chk($sformatf("r%0d_rc_result", t), int'(cmd.o_result),
            int'(exp_q[k-1]));
        ok = (fr_log.size() == k);
        for (int j = 0; ok && j < k; j++)
          if (fr_log[j] != exp_q[j]) ok = 1'b0;
        chk($sformatf("r%0d_rc_freed", t), int'(ok), 1);
      end else begin
        int n;
        bit ok;
        n = $urandom_range(0, 6);
        run_cmd(1'b0, 16'(n), n + 10, cyc, se);
        chk($sformatf("r%0d_b_cycle", t), cyc, (n == 0) ? 1 : n + 2);
        chk($sformatf("r%0d_b_count", t), int'(cmd.o_count), n);
        chk($sformatf("r%0d_b_allocs", t), al_log.size(), n);
        if (n == 0) begin
          chk($sformatf("r%0d_b_result", t), int'(cmd.o_result),
              int'(NIL));
        end else if (al_log.size() == n) begin
          chk($sformatf("r%0d_b_result", t), int'(cmd.o_result),
              int'(al_log[n-1]));
          walk(al_log[n-1]);
          ok = (wq.size() == n);
          for (int j = 0; ok && j < n; j++)
            if (wq[j] != al_log[n-1-j]) ok = 1'b0;
          chk($sformatf("r%0d_b_links", t), int'(ok), 1);
          live.push_back(al_log[n-1]);
        end
      end
    end

    chk("one_request_per_cycle", multi_viol, 0);
    chk("no_alloc_when_full", full_viol, 0);
    chk("no_request_in_err", errreq_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
